wb_stream_bridge: RTL and testbench

- Byte-stream-to-Wishbone master bridge.
- Turns a command byte stream from a host link (UART/SPI receiver) into 8-bit Wishbone cycles on the mainboard `wb_*` slave port.
- Loads console ROM, GROM, cartridge ROM, speech ROM and PEB images, and reads back VDP RAM for debug.
- Sits directly upstream of the mainboard Wishbone port and returns read data on a byte stream.

---
 rtl/wb_stream_pkg.sv | 25 ++
 rtl/wb_stream_bridge.sv | 235 +++++++++++++++++++++++
 tb/tb_wb_stream_bridge.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stream_pkg.sv
// Shared definitions for the byte-stream to Wishbone master bridge:
// command codes, controller states and the status byte prefix.
package wb_stream_pkg;

   // Host command bytes
   localparam logic [7:0] CMD_ADDR   = 8'h41;  // 'A' + 3 address bytes
   localparam logic [7:0] CMD_WRITE  = 8'h57;  // 'W' + L + (L+1) data bytes
   localparam logic [7:0] CMD_READ   = 8'h52;  // 'R' + L -> (L+1) read bytes
   localparam logic [7:0] CMD_STATUS = 8'h53;  // 'S' -> status byte

   // Upper seven bits of the status byte; the LSB carries the error flag
   localparam logic [6:0] STATUS_PREFIX = 7'b1010010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_LEN,
      ST_WDATA,
      ST_WBUS,
      ST_RBUS,
      ST_RSEND,
      ST_STATUS
   } state_t;

endpackage

// File: rtl/wb_stream_bridge.sv
// Byte-stream command decoder driving 8-bit Wishbone master cycles.
// Address/length/data arrive on rx, read results and status leave on tx.
// Every bus cycle is guarded by an ack timeout that completes the cycle
// with an error (reads return 0xFF) if the slave never responds.
module wb_stream_bridge
   import wb_stream_pkg::*;
#(
   parameter int TIMEOUT_BITS = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [0:7]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [0:7]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [0:23] wb_adr_o,
   output logic [0:7]  wb_dat_o,
   input  logic [0:7]  wb_dat_i,
   output logic        wb_we_o,
   output logic [0:0]  wb_sel_o,
   output logic        wb_stb_o,
   output logic        wb_cyc_o,
   input  logic        wb_ack_i,
   output logic        busy,
   output logic        error
);

   localparam logic [TIMEOUT_BITS-1:0] TMO_MAX = '1;

   state_t                  state_q, state_d;
   logic [0:23]             adr_q, adr_d;
   logic [0:7]              dat_q, dat_d;
   logic                    we_q, we_d;
   logic                    stb_q, stb_d;
   logic [0:7]              tx_data_q, tx_data_d;
   logic                    error_q, error_d;
   logic [7:0]              len_q, len_d;
   logic [1:0]              abyte_q, abyte_d;
   logic                    is_read_q, is_read_d;
   logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
   logic                    live_q;

   logic rx_fire;
   logic tx_fire;
   logic bus_ack;
   logic bus_tmo;
   logic bus_done;
   logic error_set;
   logic error_clr;

   // Handshakes and bus-cycle completion; ack only counts while stb is high
   assign rx_fire  = rx_valid & rx_ready;
   assign tx_fire  = tx_valid & tx_ready;
   assign bus_ack  = stb_q & wb_ack_i;
   assign bus_tmo  = stb_q & ~wb_ack_i & (tmo_q == TMO_MAX);
   assign bus_done = bus_ack | bus_tmo;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (rx_fire) begin
               case (rx_data)
                  CMD_ADDR:   state_d = ST_ADDR;
                  CMD_WRITE:  state_d = ST_LEN;
                  CMD_READ:   state_d = ST_LEN;
                  CMD_STATUS: state_d = ST_STATUS;
                  default:    state_d = ST_IDLE;
               endcase
            end
         end
         ST_ADDR:   if (rx_fire && abyte_q == 2'd2) state_d = ST_IDLE;
         ST_LEN:    if (rx_fire) state_d = is_read_q ? ST_RBUS : ST_WDATA;
         ST_WDATA:  if (rx_fire) state_d = ST_WBUS;
         ST_WBUS:   if (bus_done) state_d = (len_q == 8'd0) ? ST_IDLE : ST_WDATA;
         ST_RBUS:   if (bus_done) state_d = ST_RSEND;
         ST_RSEND:  if (tx_fire) state_d = (len_q == 8'd0) ? ST_IDLE : ST_RBUS;
         ST_STATUS: if (tx_fire) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Stream-side outputs decoded from the state; rx stays closed until the
   // first edge after reset so the host never sees ready during reset
   always_comb begin
      rx_ready = 1'b0;
      tx_valid = 1'b0;
      busy     = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE, ST_ADDR, ST_LEN, ST_WDATA: rx_ready = live_q;
         ST_RSEND, ST_STATUS:                tx_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath registers: address, bus cycle signals, counters, response byte
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         adr_q     <= '0;
         dat_q     <= '0;
         we_q      <= 1'b0;
         stb_q     <= 1'b0;
         tx_data_q <= '0;
         error_q   <= 1'b0;
         len_q     <= '0;
         abyte_q   <= '0;
         is_read_q <= 1'b0;
         tmo_q     <= '0;
         live_q    <= 1'b0;
      end else begin
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         we_q      <= we_d;
         stb_q     <= stb_d;
         tx_data_q <= tx_data_d;
         error_q   <= error_d;
         len_q     <= len_d;
         abyte_q   <= abyte_d;
         is_read_q <= is_read_d;
         tmo_q     <= tmo_d;
         live_q    <= 1'b1;
      end
   end

   // Datapath next values; tmo counts stb-high cycles including the current one
   always_comb begin
      adr_d     = adr_q;
      dat_d     = dat_q;
      we_d      = we_q;
      stb_d     = stb_q;
      tx_data_d = tx_data_q;
      len_d     = len_q;
      abyte_d   = abyte_q;
      is_read_d = is_read_q;
      error_set = 1'b0;
      error_clr = 1'b0;
      tmo_d     = (stb_q && !bus_done) ? tmo_q + 1'b1 : '0;

      case (state_q)
         ST_IDLE: begin
            if (rx_fire) begin
               abyte_d   = 2'd0;
               is_read_d = (rx_data == CMD_READ);
               case (rx_data)
                  CMD_ADDR, CMD_WRITE, CMD_READ: ;
                  CMD_STATUS: tx_data_d = {STATUS_PREFIX, error_q};
                  default:    error_set = 1'b1;
               endcase
            end
         end
         ST_ADDR: begin
            if (rx_fire) begin
               case (abyte_q)
                  2'd0:    adr_d[0:7]   = rx_data;
                  2'd1:    adr_d[8:15]  = rx_data;
                  default: adr_d[16:23] = rx_data;
               endcase
               abyte_d = abyte_q + 2'd1;
            end
         end
         ST_LEN: begin
            if (rx_fire) begin
               len_d = rx_data;
               if (is_read_q) begin
                  stb_d = 1'b1;
                  we_d  = 1'b0;
                  tmo_d = 1;
               end
            end
         end
         ST_WDATA: begin
            if (rx_fire) begin
               dat_d = rx_data;
               we_d  = 1'b1;
               stb_d = 1'b1;
               tmo_d = 1;
            end
         end
         ST_WBUS: begin
            if (bus_done) begin
               stb_d     = 1'b0;
               we_d      = 1'b0;
               adr_d     = adr_q + 24'd1;
               error_set = bus_tmo;
               if (len_q != 8'd0) len_d = len_q - 8'd1;
            end
         end
         ST_RBUS: begin
            if (bus_done) begin
               stb_d     = 1'b0;
               adr_d     = adr_q + 24'd1;
               tx_data_d = bus_ack ? wb_dat_i : 8'hFF;
               error_set = bus_tmo;
            end
         end
         ST_RSEND: begin
            if (tx_fire && len_q != 8'd0) begin
               len_d = len_q - 8'd1;
               stb_d = 1'b1;
               we_d  = 1'b0;
               tmo_d = 1;
            end
         end
         ST_STATUS: begin
            if (tx_fire) error_clr = 1'b1;
         end
         default: ;
      endcase

      // A new error on the same edge as a status read must not be lost
      error_d = error_set | (error_q & ~error_clr);
   end

   assign tx_data  = tx_data_q;
   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_we_o  = we_q;
   assign wb_stb_o = stb_q;
   assign wb_cyc_o = stb_q;
   assign wb_sel_o = stb_q;
   assign error    = error_q;

endmodule

// File: tb/tb_wb_stream_bridge.sv
// Directed self-checking bench for wb_stream_bridge with a simple
// memory-backed Wishbone slave whose ack can be disabled.
module tb_wb_stream_bridge;

   logic        clk;
   logic        reset;
   logic [0:7]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [0:7]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [0:23] wb_adr_o;
   logic [0:7]  wb_dat_o;
   logic [0:7]  wb_dat_i;
   logic        wb_we_o;
   logic [0:0]  wb_sel_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic        wb_ack_i;
   logic        busy;
   logic        error;

   int n_vec;
   int n_err;

   // Slave model state
   logic        slave_en;
   logic [7:0]  mem [logic [23:0]];
   logic [23:0] wlog_adr[$];
   logic [7:0]  wlog_dat[$];
   logic [23:0] rlog_adr[$];

   // Monitor state
   int sig_viol;
   int overlap;
   int stb_cycles;
   int run;
   int last_run;

   wb_stream_bridge #(.TIMEOUT_BITS(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_dat_i (wb_dat_i),
      .wb_we_o  (wb_we_o),
      .wb_sel_o (wb_sel_o),
      .wb_stb_o (wb_stb_o),
      .wb_cyc_o (wb_cyc_o),
      .wb_ack_i (wb_ack_i),
      .busy     (busy),
      .error    (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-cycle combinational ack slave
   assign wb_ack_i = wb_stb_o & slave_en;

   always @(negedge clk) begin
      if (mem.exists(wb_adr_o)) wb_dat_i = mem[wb_adr_o];
      else                      wb_dat_i = 8'h00;
   end

   always @(posedge clk) begin
      if (wb_stb_o && wb_ack_i) begin
         if (wb_we_o) begin
            mem[wb_adr_o] = wb_dat_o;
            wlog_adr.push_back(wb_adr_o);
            wlog_dat.push_back(wb_dat_o);
            $display("  wb write adr=%06h dat=%02h", wb_adr_o, wb_dat_o);
         end else begin
            rlog_adr.push_back(wb_adr_o);
            $display("  wb read  adr=%06h dat=%02h", wb_adr_o, wb_dat_i);
         end
      end
   end

   always @(negedge clk) begin
      if (wb_cyc_o !== wb_stb_o || wb_sel_o[0] !== wb_stb_o) sig_viol++;
      if (tx_valid && wb_stb_o) overlap++;
      if (wb_stb_o) begin
         stb_cycles++;
         run++;
      end else begin
         if (run != 0) last_run = run;
         run = 0;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL rx_accept_timeout: rx_ready=%0b required 1 for byte %02h", rx_ready, b);
         rx_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      $display("  rx byte %02h", b);
   endtask

   task automatic recv_byte_hold(input int hold, output logic [7:0] b);
      int n;
      n = 0;
      b = 8'h00;
      while (!tx_valid && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!tx_valid) begin
         n_vec++;
         n_err++;
         $display("FAIL tx_valid_timeout: tx_valid=%0b required 1", tx_valid);
         return;
      end
      b = tx_data;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         n_vec++;
         if (tx_valid !== 1'b1 || tx_data !== b) begin
            n_err++;
            $display("FAIL tx_hold_stable: tx_valid=%0b tx_data=%02h required 1/%02h",
                     tx_valid, tx_data, b);
         end
      end
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
      $display("  tx byte %02h", b);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         n_vec++;
         n_err++;
         $display("FAIL idle_timeout: busy=%0b required 0", busy);
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_ready = 1'b0;
      slave_en = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({rx_ready, tx_valid, busy, error} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_flags: rx_ready/tx_valid/busy/error=%04b required 0000",
                  {rx_ready, tx_valid, busy, error});
      end
      n_vec++;
      if (tx_data !== 8'h00) begin
         n_err++;
         $display("FAIL reset_tx_data: got %02h required 00", tx_data);
      end
      n_vec++;
      if ({wb_stb_o, wb_cyc_o, wb_we_o, wb_sel_o} !== 4'b0000 || wb_adr_o !== 24'h0 ||
          wb_dat_o !== 8'h00) begin
         n_err++;
         $display("FAIL reset_wb: stb=%0b cyc=%0b we=%0b sel=%0b adr=%06h dat=%02h required all 0",
                  wb_stb_o, wb_cyc_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o);
      end
      reset = 1'b0;
      #1;
      n_vec++;
      if (rx_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release_ready: got %0b required 0 before first edge", rx_ready);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (rx_ready !== 1'b1) begin
         n_err++;
         $display("FAIL first_edge_ready: got %0b required 1", rx_ready);
      end
      $display("  reset sequence done");
   endtask

   task automatic test_write_read();
      int         wb, rb;
      logic [7:0] b;
      wb = wlog_adr.size();
      send_byte(8'h41); send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
      send_byte(8'h57); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
      wait_idle();
      n_vec++;
      if (wlog_adr.size() - wb !== 2) begin
         n_err++;
         $display("FAIL wr_count: got %0d writes required 2", wlog_adr.size() - wb);
      end else begin
         n_vec++;
         if (wlog_adr[wb] !== 24'h012345 || wlog_dat[wb] !== 8'hAA) begin
            n_err++;
            $display("FAIL wr_first: got %06h:%02h required 012345:AA", wlog_adr[wb], wlog_dat[wb]);
         end
         n_vec++;
         if (wlog_adr[wb+1] !== 24'h012346 || wlog_dat[wb+1] !== 8'hBB) begin
            n_err++;
            $display("FAIL wr_second: got %06h:%02h required 012346:BB", wlog_adr[wb+1], wlog_dat[wb+1]);
         end
      end
      n_vec++;
      if (wb_adr_o !== 24'h012347) begin
         n_err++;
         $display("FAIL wr_addr_after: got %06h required 012347", wb_adr_o);
      end
      rb = rlog_adr.size();
      send_byte(8'h41); send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
      send_byte(8'h52); send_byte(8'h01);
      recv_byte_hold(0, b);
      n_vec++;
      if (b !== 8'hAA) begin
         n_err++;
         $display("FAIL rd_first: got %02h required AA", b);
      end
      recv_byte_hold(0, b);
      n_vec++;
      if (b !== 8'hBB) begin
         n_err++;
         $display("FAIL rd_second: got %02h required BB", b);
      end
      wait_idle();
      n_vec++;
      if (rlog_adr.size() - rb !== 2) begin
         n_err++;
         $display("FAIL rd_count: got %0d reads required 2", rlog_adr.size() - rb);
      end
   endtask

   task automatic test_wrap();
      int wb;
      wb = wlog_adr.size();
      send_byte(8'h41); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
      send_byte(8'h57); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
      wait_idle();
      n_vec++;
      if (wlog_adr.size() - wb !== 2) begin
         n_err++;
         $display("FAIL wrap_count: got %0d writes required 2", wlog_adr.size() - wb);
      end else begin
         n_vec++;
         if (wlog_adr[wb] !== 24'hFFFFFF || wlog_dat[wb] !== 8'h11) begin
            n_err++;
            $display("FAIL wrap_first: got %06h:%02h required FFFFFF:11", wlog_adr[wb], wlog_dat[wb]);
         end
         n_vec++;
         if (wlog_adr[wb+1] !== 24'h000000 || wlog_dat[wb+1] !== 8'h22) begin
            n_err++;
            $display("FAIL wrap_second: got %06h:%02h required 000000:22", wlog_adr[wb+1], wlog_dat[wb+1]);
         end
      end
   endtask

   task automatic test_timeout();
      logic [7:0] b;
      send_byte(8'h41); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
      slave_en = 1'b0;
      send_byte(8'h52); send_byte(8'h00);
      recv_byte_hold(0, b);
      n_vec++;
      if (last_run !== 255) begin
         n_err++;
         $display("FAIL tmo_stb_cycles: got %0d required 255", last_run);
      end
      n_vec++;
      if (b !== 8'hFF) begin
         n_err++;
         $display("FAIL tmo_read_data: got %02h required FF", b);
      end
      wait_idle();
      slave_en = 1'b1;
      n_vec++;
      if (error !== 1'b1) begin
         n_err++;
         $display("FAIL tmo_error: got %0b required 1", error);
      end
      n_vec++;
      if (wb_adr_o !== 24'h000011) begin
         n_err++;
         $display("FAIL tmo_addr_inc: got %06h required 000011", wb_adr_o);
      end
      send_byte(8'h53);
      recv_byte_hold(0, b);
      n_vec++;
      if (b !== 8'hA5) begin
         n_err++;
         $display("FAIL status_err: got %02h required A5", b);
      end
      send_byte(8'h53);
      recv_byte_hold(0, b);
      n_vec++;
      if (b !== 8'hA4) begin
         n_err++;
         $display("FAIL status_clear: got %02h required A4", b);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] b;
      logic [7:0] exp_b [4];
      int         ov0, rb;
      exp_b[0] = 8'h10; exp_b[1] = 8'h20; exp_b[2] = 8'h30; exp_b[3] = 8'h40;
      send_byte(8'h41); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h57); send_byte(8'h03);
      for (int i = 0; i < 4; i++) send_byte(exp_b[i]);
      wait_idle();
      send_byte(8'h41); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
      ov0 = overlap;
      rb  = rlog_adr.size();
      send_byte(8'h52); send_byte(8'h03);
      for (int i = 0; i < 4; i++) begin
         recv_byte_hold(6, b);
         n_vec++;
         if (b !== exp_b[i]) begin
            n_err++;
            $display("FAIL bp_data%0d: got %02h required %02h", i, b, exp_b[i]);
         end
      end
      wait_idle();
      n_vec++;
      if (rlog_adr.size() - rb !== 4) begin
         n_err++;
         $display("FAIL bp_count: got %0d reads required 4", rlog_adr.size() - rb);
      end
      n_vec++;
      if (overlap !== ov0) begin
         n_err++;
         $display("FAIL bp_outstanding: got %0d cycles with stb during tx_valid required 0", overlap - ov0);
      end
   endtask

   task automatic test_unknown();
      int         sc;
      logic [7:0] b;
      sc = stb_cycles;
      send_byte(8'h00);
      repeat (3) @(negedge clk);
      n_vec++;
      if (stb_cycles !== sc) begin
         n_err++;
         $display("FAIL unk_no_bus: got %0d stb cycles required 0", stb_cycles - sc);
      end
      n_vec++;
      if (error !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL unk_error: error=%0b busy=%0b required 1/0", error, busy);
      end
      send_byte(8'h41); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
      wait_idle();
      n_vec++;
      if (wb_adr_o !== 24'h000007) begin
         n_err++;
         $display("FAIL unk_next_addr: got %06h required 000007", wb_adr_o);
      end
      send_byte(8'h53);
      recv_byte_hold(0, b);
      n_vec++;
      if (b !== 8'hA5) begin
         n_err++;
         $display("FAIL unk_status: got %02h required A5", b);
      end
   endtask

   task automatic test_reset_mid_write();
      send_byte(8'h41); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
      slave_en = 1'b0;
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h55);
      n_vec++;
      if (wb_stb_o !== 1'b1) begin
         n_err++;
         $display("FAIL mid_stb_high: got %0b required 1", wb_stb_o);
      end
      #2;
      reset = 1'b1;
      #1;
      n_vec++;
      if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
         n_err++;
         $display("FAIL mid_async_drop: stb=%0b cyc=%0b required 0/0", wb_stb_o, wb_cyc_o);
      end
      slave_en = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_vec++;
      if (busy !== 1'b0 || wb_adr_o !== 24'h0 || rx_ready !== 1'b1) begin
         n_err++;
         $display("FAIL mid_after_release: busy=%0b adr=%06h rx_ready=%0b required 0/000000/1",
                  busy, wb_adr_o, rx_ready);
      end
      $display("  reset during write done");
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      sig_viol   = 0;
      overlap    = 0;
      stb_cycles = 0;
      run        = 0;
      last_run   = 0;
      test_reset();
      test_write_read();
      test_wrap();
      test_timeout();
      test_backpressure();
      test_unknown();
      test_reset_mid_write();
      n_vec++;
      if (sig_viol !== 0) begin
         n_err++;
         $display("FAIL cyc_sel_track: got %0d cycles with cyc/sel != stb required 0", sig_viol);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
